// File: rtl/memory_port_bridge_pkg.sv
// Shared encodings and helpers for the CPU-to-memory-port bridge.
package memory_port_bridge_pkg;

  // Access size encodings carried on cpu_size.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_INV  = 2'b11;

  // Bridge FSM states; the encoding is visible on the state_dbg port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // True when the request can never reach memory: bad alignment or bad size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte write-enables for an aligned store.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << {off[1], 1'b0};
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-justified store data replicated across every lane it could land in,
  // so the write-enables alone pick the destination bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = 32'h0;
    case (size)
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      SIZE_WORD: d = wdata;
      default:   d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/memory_port_bridge_load_align.sv
// Combinational load alignment: picks the addressed lane out of the memory
// word and sign- or zero-extends it to 32 bits.
module memory_port_bridge_load_align
  import memory_port_bridge_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data_out
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection from the latched byte offset.
  always_comb begin
    byte_lane = word_in[7:0];
    case (off)
      2'd0:    byte_lane = word_in[7:0];
      2'd1:    byte_lane = word_in[15:8];
      2'd2:    byte_lane = word_in[23:16];
      default: byte_lane = word_in[31:24];
    endcase
    half_lane = off[1] ? word_in[31:16] : word_in[15:0];
  end

  // Extension by size and signedness; an invalid size never reaches here but yields 0.
  always_comb begin
    data_out = 32'h0;
    case (size)
      SIZE_BYTE: data_out = {{24{sign & byte_lane[7]}}, byte_lane};
      SIZE_HALF: data_out = {{16{sign & half_lane[15]}}, half_lane};
      SIZE_WORD: data_out = word_in;
      default:   data_out = 32'h0;
    endcase
  end

endmodule

// File: rtl/memory_port_bridge.sv
// Bridge from a byte-addressed CPU load/store interface to a single word-wide
// memory port. Handshake: the CPU holds cpu_req (and its fields) high until it
// sees the one-cycle cpu_done pulse; the bridge strobes mem_enable for exactly
// one cycle and treats mem_ready as meaningful only while it is waiting.
module memory_port_bridge
  import memory_port_bridge_pkg::*;
#(
  parameter int addr_size      = 8,
  parameter int timeout_cycles = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [1:0]           cpu_size,
  input  logic                 cpu_sign,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_done,
  output logic                 cpu_stall,
  output logic                 cpu_err_align,
  output logic                 cpu_err_timeout,
  output logic [addr_size-1:0] mem_addr,
  output logic [31:0]          mem_din,
  output logic [3:0]           mem_wr,
  output logic                 mem_enable,
  input  logic [31:0]          mem_dout,
  input  logic                 mem_ready,
  output logic [1:0]           state_dbg
);

  localparam logic [7:0] TIMEOUT = 8'(timeout_cycles);

  state_t      state_q, state_d;
  logic        accept, align_err, wait_ok, wait_timeout;
  logic        we_q, sign_q;
  logic [1:0]  size_q, off_q;
  logic [7:0]  count_q, count_inc;
  logic [31:0] load_data;

  // Address bits above the memory window alias onto it.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[31:addr_size+2];

  assign cpu_stall = cpu_req & ~cpu_done;
  assign state_dbg = state_q;
  assign count_inc = count_q + 8'd1;

  memory_port_bridge_load_align u_load_align (
    .word_in  (mem_dout),
    .off      (off_q),
    .size     (size_q),
    .sign     (sign_q),
    .data_out (load_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the one-cycle memory strobe.
  always_comb begin
    state_d      = state_q;
    mem_enable   = 1'b0;
    accept       = 1'b0;
    align_err    = 1'b0;
    wait_ok      = 1'b0;
    wait_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // cpu_done still high means the CPU has not yet dropped the old request.
        if (cpu_req && !cpu_done) begin
          accept = 1'b1;
          if (is_misaligned(cpu_size, cpu_addr[1:0])) align_err = 1'b1;
          else                                         state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_enable = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready) begin
          wait_ok = 1'b1;
          state_d = ST_IDLE;
        end else if (count_inc == TIMEOUT) begin
          wait_timeout = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, memory-side registers, timeout counter and CPU completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q            <= 1'b0;
      sign_q          <= 1'b0;
      size_q          <= SIZE_BYTE;
      off_q           <= 2'b00;
      count_q         <= 8'd0;
      mem_addr        <= '0;
      mem_din         <= 32'h0;
      mem_wr          <= 4'b0000;
      cpu_rdata       <= 32'h0;
      cpu_done        <= 1'b0;
      cpu_err_align   <= 1'b0;
      cpu_err_timeout <= 1'b0;
    end else begin
      cpu_done        <= 1'b0;
      cpu_err_align   <= 1'b0;
      cpu_err_timeout <= 1'b0;

      if (accept) begin
        we_q   <= cpu_we;
        sign_q <= cpu_sign;
        size_q <= cpu_size;
        off_q  <= cpu_addr[1:0];
        if (align_err) begin
          cpu_done      <= 1'b1;
          cpu_err_align <= 1'b1;
          cpu_rdata     <= 32'h0;
        end else begin
          mem_addr <= cpu_addr[addr_size+1:2];
          mem_wr   <= cpu_we ? byte_enables(cpu_size, cpu_addr[1:0]) : 4'b0000;
          mem_din  <= store_data(cpu_size, cpu_wdata);
        end
      end

      // Write-enables are only meaningful alongside the strobe.
      if (state_q == ST_ACCESS) begin
        count_q <= 8'd0;
        mem_wr  <= 4'b0000;
      end

      if (wait_ok) begin
        cpu_done  <= 1'b1;
        cpu_rdata <= we_q ? 32'h0 : load_data;
      end else if (wait_timeout) begin
        cpu_done        <= 1'b1;
        cpu_err_timeout <= 1'b1;
        cpu_rdata       <= 32'h0;
      end else if (state_q == ST_WAIT) begin
        count_q <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_memory_port_bridge.sv
// Directed bench for memory_port_bridge with a small behavioural memory on port B.
module tb_memory_port_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_sign = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_stall, cpu_err_align, cpu_err_timeout;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wr;
  logic        mem_enable;
  logic [31:0] mem_dout;
  logic        mem_ready;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  memory_port_bridge #(.addr_size(8), .timeout_cycles(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .cpu_err_align(cpu_err_align), .cpu_err_timeout(cpu_err_timeout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_enable(mem_enable),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: registered access, ready one cycle after enable, echoes
  // the written word on stores. Outside ready the bus carries junk.
  logic [31:0] mem_arr [256];
  logic [31:0] rd_q = 32'h0;
  logic        ready_q = 1'b0;
  logic        ready_en = 1'b1;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] din,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = din[b*8 +: 8];
    return w;
  endfunction

  initial for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;

  always @(posedge clk) begin
    ready_q <= mem_enable & ready_en;
    if (mem_enable) begin
      mem_arr[mem_addr] <= merge(mem_arr[mem_addr], mem_din, mem_wr);
      rd_q              <= merge(mem_arr[mem_addr], mem_din, mem_wr);
    end
  end

  assign mem_ready = ready_q;
  assign mem_dout  = ready_q ? rd_q : 32'h5A5A5A5A;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Results of the last transaction, captured by the driver.
  logic [31:0] r_rdata;
  logic        r_ea, r_et;
  int          r_lat, r_en;
  logic [7:0]  cap_addr;
  logic [3:0]  cap_wr;
  logic [31:0] cap_din;

  // Driver: issue one request and hold it until cpu_done (bounded).
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit seen;
    seen = 1'b0;
    r_lat = 0; r_en = 0; r_rdata = 32'h0; r_ea = 1'b0; r_et = 1'b0;
    cap_addr = 8'h0; cap_wr = 4'h0; cap_din = 32'h0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sign = sign;
    cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      r_lat++;
      if (mem_enable) begin
        r_en++;
        cap_addr = mem_addr; cap_wr = mem_wr; cap_din = mem_din;
      end
      if (cpu_done) begin
        seen = 1'b1;
        r_rdata = cpu_rdata; r_ea = cpu_err_align; r_et = cpu_err_timeout;
      end
    end
    cpu_req = 1'b0;
    check("done_within_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_done_flags", {29'h0, cpu_done, cpu_err_align, cpu_err_timeout}, 32'h0);
    check("rst_mem_side", {23'h0, mem_enable, mem_addr}, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);

    // Word store
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_addr", 32'(cap_addr), 32'h4);
    check("sw_wr", 32'(cap_wr), 32'hF);
    check("sw_din", cap_din, 32'hDEADBEEF);
    check("sw_enables", r_en, 1);
    check("sw_latency", r_lat, 3);
    check("sw_flags", {30'h0, r_ea, r_et}, 32'h0);

    // Byte store into top lane, then read the word back
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    check("sb_wr", 32'(cap_wr), 32'h8);
    check("sb_din", cap_din, 32'hA5A5A5A5);
    check("sb_rdata", r_rdata, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_after_sb", r_rdata, 32'hA5ADBEEF);
    check("lw_wr", 32'(cap_wr), 32'h0);

    // Half store to upper half, then signed/unsigned half loads
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h12348001);
    check("sh_wr", 32'(cap_wr), 32'hC);
    check("sh_din", cap_din, 32'h80018001);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lh_signed", r_rdata, 32'hFFFF8001);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh_unsigned", r_rdata, 32'h00008001);

    // Byte loads: word at 0x10 is now 0x8001BEEF
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lbu_top", r_rdata, 32'h00000080);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_top", r_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    check("lb_low", r_rdata, 32'hFFFFFFEF);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("lbu_lane1", r_rdata, 32'h000000BE);

    // Aliased address bits above the window
    issue(1'b0, 2'b10, 1'b0, 32'h00000410, 32'h0);
    check("alias_addr", 32'(cap_addr), 32'h4);
    check("alias_rdata", r_rdata, 32'h8001BEEF);

    // Misaligned and invalid-size requests
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    check("mis_w_latency", r_lat, 1);
    check("mis_w_enables", r_en, 0);
    check("mis_w_flags", {30'h0, r_ea, r_et}, 32'h2);
    check("mis_w_rdata", r_rdata, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
    check("mis_h_flags", {30'h0, r_ea, r_et}, 32'h2);
    check("mis_h_enables", r_en, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("inv_size_flags", {30'h0, r_ea, r_et}, 32'h2);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("after_mis_word", r_rdata, 32'h8001BEEF);

    // Timeout with ready tied low: 1 accept + 1 access + 15 wait cycles
    ready_en = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("to_latency", r_lat, 17);
    check("to_flags", {30'h0, r_ea, r_et}, 32'h1);
    check("to_rdata", r_rdata, 32'h0);
    check("to_state_idle", 32'(state_dbg), 32'd0);

    // Reset while waiting
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h10;
    repeat (3) @(negedge clk);
    check("pre_rst_state", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_outs", {23'h0, cpu_done, mem_enable, mem_wr, cpu_err_timeout, cpu_err_align}, 32'h0);
    check("mid_rst_addr", 32'(mem_addr), 32'h0);
    rst = 1'b0; cpu_req = 1'b0;
    begin
      int dones;
      dones = 0;
      repeat (4) begin
        @(negedge clk);
        if (cpu_done) dones++;
      end
      check("mid_rst_no_done", dones, 0);
    end
    ready_en = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("post_rst_rdata", r_rdata, 32'h8001BEEF);
    check("post_rst_latency", r_lat, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
